// File: rtl/kernel_stream_loader_if.sv
// Weight RAM read port plus conv3d kernel-load port, shared by the loader and its consumer.
interface kernel_stream_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  kernel_clear;
    logic                  load_kernel;
    logic [DATA_WIDTH-1:0] kernel;
    logic                  load_kernel_done;

    modport master (
        output mem_rd_en, mem_addr, kernel_clear, load_kernel, kernel,
        input  mem_rd_data, load_kernel_done
    );
    modport slave (
        input  mem_rd_en, mem_addr, kernel_clear, load_kernel, kernel,
        output mem_rd_data, load_kernel_done
    );
endinterface

// File: rtl/kernel_stream_loader.sv
// Streams one filter's packed coefficients from weight RAM into a conv3d kernel block,
// then closes the transfer on the block's load_kernel_done acknowledge.
module kernel_stream_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int SIZE         = 3,
    parameter int CHANNEL      = 8,
    parameter int NUM_FILTERS  = 64,
    parameter int ADDR_WIDTH   = 16,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [15:0]           filter_idx,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  pause,
    kernel_stream_loader_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int TOTAL = CHANNEL*(SIZE*SIZE+1)+1;
    localparam int CW    = $clog2(TOTAL);
    localparam int TW    = $clog2(DONE_TIMEOUT+1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_WAIT_ACK} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_rd_cnt;
    logic [TW-1:0]         r_to_cnt;
    logic                  r_ack;
    logic                  r_bad_idx;
    logic [1:0]            r_vld_pipe;
    logic [DATA_WIDTH-1:0] r_kernel;
    logic                  w_rd, w_done, w_err, w_bad, w_accept;
    logic [31:0]           w_off;

    assign w_off    = 32'(filter_idx) * 32'(TOTAL);
    assign w_bad    = 32'(filter_idx) >= 32'(NUM_FILTERS);
    assign w_accept = (r_state == S_IDLE) && start && !w_bad;

    // The acknowledge is registered first: done lands one cycle after the ack,
    // and an early ack aborts the transfer before any further read.
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CLEAR;
            S_CLEAR: begin
                if (r_ack) begin w_err = 1'b1; w_next = S_IDLE; end
                else w_next = S_STREAM;
            end
            S_STREAM: begin
                if (r_ack) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (!pause) begin
                    w_rd = 1'b1;
                    if (r_rd_cnt == CW'(TOTAL-1)) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_ack) begin w_err = 1'b1; w_next = S_IDLE; end
                else if (!r_vld_pipe[0]) w_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (r_ack) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (r_to_cnt == TW'(DONE_TIMEOUT)) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rd_cnt   <= '0;
            r_to_cnt   <= '0;
            r_ack      <= 1'b0;
            r_bad_idx  <= 1'b0;
            r_vld_pipe <= '0;
            r_kernel   <= '0;
        end else begin
            r_state   <= w_next;
            r_ack     <= bus.load_kernel_done && (r_state != S_IDLE);
            r_bad_idx <= (r_state == S_IDLE) && start && w_bad;
            if (w_accept) begin
                r_addr   <= base_addr + w_off[ADDR_WIDTH-1:0];
                r_rd_cnt <= '0;
            end else if (w_rd) begin
                r_addr   <= r_addr + 1'b1;
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            r_to_cnt   <= (r_state == S_WAIT_ACK) ? r_to_cnt + 1'b1 : '0;
            r_vld_pipe <= {r_vld_pipe[0], w_rd};
            if (r_vld_pipe[0]) r_kernel <= bus.mem_rd_data;
        end
    end

    assign bus.mem_rd_en    = w_rd;
    assign bus.mem_addr     = r_addr;
    assign bus.kernel_clear = (r_state == S_CLEAR);
    assign bus.load_kernel  = r_vld_pipe[1];
    assign bus.kernel       = r_kernel;
    assign busy             = (r_state != S_IDLE);
    assign done             = w_done;
    assign error            = w_err | r_bad_idx;
endmodule

// File: tb/tb_kernel_stream_loader.sv
// Directed bench for kernel_stream_loader: table of transfer scenarios plus reset and
// back-to-back conv3d-consumer sequences.
module tb_kernel_stream_loader;
    logic        clk;
    logic        resetn;
    logic        start;
    logic [15:0] filter_idx;
    logic [15:0] base_addr;
    logic        pause;
    logic        busy, done, error;
    logic        ack_tbl, ack_cons;

    int n_chk  = 0;
    int n_fail = 0;

    kernel_stream_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    kernel_stream_loader dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .filter_idx (filter_idx),
        .base_addr  (base_addr),
        .pause      (pause),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight RAM: word at address a holds a, one-cycle read latency.
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= 32'(bus.mem_addr);

    assign bus.load_kernel_done = ack_tbl | ack_cons;

    // Minimal conv3d kernel block: counts words, captures the bias, acks once.
    logic        cons_en;
    int          cons_cnt, n_ack, n_done_c, n_err_c;
    logic [31:0] bias_cap [2];
    always @(posedge clk) begin
        if (!cons_en) begin
            cons_cnt <= 0;
            ack_cons <= 1'b0;
        end else begin
            ack_cons <= 1'b0;
            if (bus.kernel_clear) cons_cnt <= 0;
            else if (bus.load_kernel) begin
                cons_cnt <= cons_cnt + 1;
                if (cons_cnt == 80) begin
                    if (n_ack < 2) bias_cap[n_ack] <= bus.kernel;
                    n_ack    <= n_ack + 1;
                    ack_cons <= 1'b1;
                end
            end
            if (done)  n_done_c <= n_done_c + 1;
            if (error) n_err_c  <= n_err_c + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int idx, base, plo, phi, ack_c, rst_c, st2_c;
        int e_clear, e_first, e_last, e_nw, e_reads, e_done, e_err, e_idle;
    } vec_t;

    task automatic run_vec(input int vi, input vec_t v);
        int c_clear = 0, c_first = 0, c_last = 0, c_done = 0, c_err = 0, c_idle = 0;
        int nw = 0, nrd = 0, bad = 0;
        logic [15:0] a;
        filter_idx = 16'(v.idx);
        base_addr  = 16'(v.base);
        start      = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 110; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start   = (c == v.st2_c);
            if (c == v.st2_c) filter_idx = 16'd5;
            pause   = (c >= v.plo && c <= v.phi);
            ack_tbl = (c == v.ack_c);
            resetn  = (c == v.rst_c);
            #1;
            if (bus.kernel_clear && c_clear == 0) c_clear = c;
            if (bus.mem_rd_en) nrd++;
            if (bus.load_kernel) begin
                if (c_first == 0) c_first = c;
                c_last = c;
                a = 16'(v.base) + 16'(v.idx * 81) + 16'(nw);
                if (bus.kernel !== {16'd0, a}) bad++;
                nw++;
            end
            if (done && c_done == 0) c_done = c;
            if (error && c_err == 0) c_err = c;
            if (!busy && c_idle == 0) c_idle = c;
        end
        start = 1'b0; pause = 1'b0; ack_tbl = 1'b0; resetn = 1'b0;
        chk($sformatf("v%0d clear_cycle", vi), c_clear, v.e_clear);
        chk($sformatf("v%0d first_word_cycle", vi), c_first, v.e_first);
        chk($sformatf("v%0d last_word_cycle", vi), c_last, v.e_last);
        chk($sformatf("v%0d word_count", vi), nw, v.e_nw);
        chk($sformatf("v%0d read_count", vi), nrd, v.e_reads);
        chk($sformatf("v%0d done_cycle", vi), c_done, v.e_done);
        chk($sformatf("v%0d error_cycle", vi), c_err, v.e_err);
        chk($sformatf("v%0d idle_cycle", vi), c_idle, v.e_idle);
        chk($sformatf("v%0d bad_words", vi), bad, 0);
    endtask

    vec_t vecs [7];

    initial begin
        //          idx  base  plo phi ack  rst st2 | clr frst last nw  rd  done err idle
        vecs[0] = '{2,   0,     0,  0, 85,   0, 30,   1,  4,  84, 81, 81,  86,   0,  87};
        vecs[1] = '{0,   0,    10, 14, 90,   0,  0,   1,  4,  89, 81, 81,  91,   0,  92};
        vecs[2] = '{63,  0,     0,  0,  0,   0,  0,   1,  4,  84, 81, 81,   0, 101, 102};
        vecs[3] = '{64,  0,     0,  0,  0,   0,  0,   0,  0,   0,  0,  0,   0,   1,   1};
        vecs[4] = '{1,   100,   0,  0, 20,   0,  0,   1,  4,  22, 19, 19,   0,  21,  22};
        vecs[5] = '{3,   0,     0,  0,  0,  40,  0,   1,  4,  40, 37, 39,   0,   0,  41};
        vecs[6] = '{0,   65520, 0,  0, 85,   0,  0,   1,  4,  84, 81, 81,  86,   0,  87};

        resetn = 1'b1; start = 1'b0; filter_idx = '0; base_addr = '0; pause = 1'b0;
        ack_tbl = 1'b0; cons_en = 1'b0; n_ack = 0; n_done_c = 0; n_err_c = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset load_kernel", int'(bus.load_kernel), 0);
        chk("reset kernel", int'(bus.kernel), 0);
        chk("reset mem_addr", int'(bus.mem_addr), 0);
        chk("reset err_done_clr_rd", int'({error, done, bus.kernel_clear, bus.mem_rd_en}), 0);
        resetn = 1'b0;
        @(posedge clk);
        #2;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Back-to-back filters 0 and 1 into the consumer model; filter 1 starts
        // in the first cycle busy is low.
        begin
            int launched = 1;
            int fin = 0;
            cons_en = 1'b1;
            filter_idx = 16'd0; base_addr = 16'd0; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            for (int c = 0; c < 400 && fin == 0; c++) begin
                @(posedge clk);
                #2;
                if (!busy) begin
                    if (launched == 1) begin
                        filter_idx = 16'd1; start = 1'b1; launched = 2;
                        @(posedge clk);
                        #1 start = 1'b0;
                    end else fin = 1;
                end
            end
            chk("b2b finished", fin, 1);
            chk("b2b ack_count", n_ack, 2);
            chk("b2b done_count", n_done_c, 2);
            chk("b2b error_count", n_err_c, 0);
            chk("b2b bias0", int'(bias_cap[0]), 80);
            chk("b2b bias1", int'(bias_cap[1]), 161);
            cons_en = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
